// File: rtl/window_stream_ctrl_if.sv
// Pixel-stream and window handshake bundle for window_stream_ctrl.
// master: the side that feeds pixels and consumes windows.
// slave:  the ingest controller itself.
interface window_stream_ctrl_if #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int PIXEL_W = 8
);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic               frame_start;
  logic [PIXEL_W-1:0] pixel_in;
  logic               pixel_valid;
  logic               pixel_ready;
  logic [PIXEL_W-1:0] buf_pixel;
  logic               buf_shift_en;
  logic               window_valid;
  logic               window_ready;
  logic [ROW_W-1:0]   window_row;
  logic [COL_W-1:0]   window_col;
  logic               frame_done;

  modport master (
    output frame_start, pixel_in, pixel_valid, window_ready,
    input  pixel_ready, buf_pixel, buf_shift_en, window_valid,
           window_row, window_col, frame_done
  );

  modport slave (
    input  frame_start, pixel_in, pixel_valid, window_ready,
    output pixel_ready, buf_pixel, buf_shift_en, window_valid,
           window_row, window_col, frame_done
  );
endinterface

// File: rtl/window_stream_ctrl.sv
// Ingest controller in front of the shifting window buffer: accepts a raster
// pixel stream, issues one buffer shift per accepted pixel, tracks the raster
// position and flags every cycle on which the buffer holds a full
// KERNEL x KERNEL window. Backpressure from the window consumer freezes the
// stream (no acceptance, no shift) until the window is taken.
// Optional feature macro: PROTOCOL_CHECK_EN adds a saturating err_count output
// counting frame_start outside IDLE and pixel_valid in IDLE or LAST.
module window_stream_ctrl #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int KERNEL  = 9,
  parameter int PIXEL_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  window_stream_ctrl_if.slave  bus
`ifdef PROTOCOL_CHECK_EN
  ,
  output logic [7:0]           err_count
`endif
);

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(KERNEL - 1);
  localparam logic [COL_W-1:0] COL_K1   = COL_W'(KERNEL - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_LAST} state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   row_cnt, pos_row;
  logic [COL_W-1:0]   col_cnt, pos_col;
  logic               stall, accept, last_pix, win_hit;
  logic               pixel_ready_c, frame_done_c;

  logic [PIXEL_W-1:0] pix_p1;
  logic               shift_p1;
  logic               win_vld_p1;
  logic [ROW_W-1:0]   win_row_p1;
  logic [COL_W-1:0]   win_col_p1;

  // A held window blocks the stream; frame_start restarts the raster at (0,0)
  // so a pixel arriving with it is placed at the origin.
  assign stall    = win_vld_p1 && !bus.window_ready;
  assign pos_row  = bus.frame_start ? '0 : row_cnt;
  assign pos_col  = bus.frame_start ? '0 : col_cnt;
  assign last_pix = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
  assign win_hit  = (pos_row >= ROW_K1) && (pos_col >= COL_K1);

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state, acceptance, ready and frame_done.
  always_comb begin
    state_nxt     = state;
    pixel_ready_c = 1'b0;
    frame_done_c  = 1'b0;
    accept        = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.frame_start) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        pixel_ready_c = !stall;
        accept        = bus.pixel_valid && !stall;
        if (accept && last_pix) state_nxt = S_LAST;
      end
      S_LAST: begin
        if (bus.frame_start) begin
          state_nxt = S_STREAM;
        end else if (win_vld_p1 && bus.window_ready) begin
          state_nxt    = S_IDLE;
          frame_done_c = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster position of the next pixel; holds at the last pixel until restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (accept) begin
      if (pos_col != COL_LAST) begin
        row_cnt <= pos_row;
        col_cnt <= pos_col + COL_W'(1);
      end else if (pos_row != ROW_LAST) begin
        row_cnt <= pos_row + ROW_W'(1);
        col_cnt <= '0;
      end else begin
        row_cnt <= pos_row;
        col_cnt <= pos_col;
      end
    end else if (bus.frame_start) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end
  end

  // ---- stage p1: buffer write strobe and window flag ----
  // Shift the accepted pixel into the buffer and raise the window flag when the
  // pixel completes a window that does not straddle a row wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_p1     <= '0;
      shift_p1   <= 1'b0;
      win_vld_p1 <= 1'b0;
      win_row_p1 <= '0;
      win_col_p1 <= '0;
    end else begin
      shift_p1 <= accept;
      if (accept) begin
        pix_p1     <= bus.pixel_in;
        win_vld_p1 <= win_hit;
        if (win_hit) begin
          win_row_p1 <= pos_row - ROW_K1;
          win_col_p1 <= pos_col - COL_K1;
        end
      end else if (bus.frame_start || bus.window_ready) begin
        win_vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.pixel_ready  = pixel_ready_c;
  assign bus.frame_done   = frame_done_c;
  assign bus.buf_pixel    = pix_p1;
  assign bus.buf_shift_en = shift_p1;
  assign bus.window_valid = win_vld_p1;
  assign bus.window_row   = win_row_p1;
  assign bus.window_col   = win_col_p1;

`ifdef PROTOCOL_CHECK_EN
  logic proto_err;
  assign proto_err = (bus.frame_start && (state != S_IDLE)) ||
                     (bus.pixel_valid && (state != S_STREAM));

  // Count protocol violations, at most one per cycle, saturating at 255.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               err_count <= 8'd0;
    else if (proto_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
